// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci sequencer and the ALU it drives.
package fib_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_SLT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        ADD,
        INC,
        DONE
    } fib_state_t;

endpackage

// File: rtl/fib_seq.sv
// Multi-cycle fib(n) controller sequencing an external shared ALU (add/slt).
// Optional busy-cycle counter output enabled by FIB_SEQ_CYCLE_CNT_EN.
module fib_seq
    import fib_pkg::*;
#(
    parameter int unsigned N_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    output logic               busy,
    output logic               done,
    output logic [31:0]        result,
    output logic               overflow,
    output logic [31:0]        alu_src0,
    output logic [31:0]        alu_src1,
    output logic [1:0]         alu_aluop,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero
`ifdef FIB_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]        cycles
`endif
);

    fib_state_t         state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  i_q, i_d;
    logic [N_WIDTH-1:0] nidx_q, nidx_d;
    logic               ovf_a_q, ovf_a_d;
    logic               ovf_b_q, ovf_b_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               overflow_q, overflow_d;

    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        i_d        = i_q;
        nidx_d     = nidx_q;
        ovf_a_d    = ovf_a_q;
        ovf_b_d    = ovf_b_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        alu_src0   = '0;
        alu_src1   = '0;
        alu_aluop  = ALUOP_ADD;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    b_d     = 32'd1;
                    i_d     = '0;
                    nidx_d  = n;
                    ovf_a_d = 1'b0;
                    ovf_b_d = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                alu_src0  = i_q;
                alu_src1  = {{(DATA_W-N_WIDTH){1'b0}}, nidx_q};
                alu_aluop = ALUOP_SLT;
                if (alu_result[0]) begin
                    state_d = ADD;
                end else begin
                    result_d   = a_q;
                    overflow_d = ovf_a_q;
                    state_d    = DONE;
                end
            end
            ADD: begin
                alu_src0  = a_q;
                alu_src1  = b_q;
                alu_aluop = ALUOP_ADD;
                a_d       = b_q;
                b_d       = alu_result;
                // overflow follows a, so it lags the carry out of the new b by one step
                ovf_a_d   = ovf_b_q;
                ovf_b_d   = ovf_b_q | (alu_result < b_q);
                state_d   = INC;
            end
            INC: begin
                alu_src0  = i_q;
                alu_src1  = 32'd1;
                alu_aluop = ALUOP_ADD;
                i_d       = alu_result;
                state_d   = CMP;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            i_q        <= '0;
            nidx_q     <= '0;
            ovf_a_q    <= 1'b0;
            ovf_b_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            i_q        <= i_d;
            nidx_q     <= nidx_d;
            ovf_a_q    <= ovf_a_d;
            ovf_b_q    <= ovf_b_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign overflow = overflow_q;

`ifdef FIB_SEQ_CYCLE_CNT_EN
    logic [15:0] cycles_q, cycles_d;

    // DONE is excluded so the count freezes at the value seen with done
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == IDLE) begin
            if (start) cycles_d = '0;
        end else if (state_q != DONE && cycles_q != '1) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_fib_seq.sv
// Scoreboard bench for fib_seq with a behavioural ALU; covers FIB_SEQ_CYCLE_CNT_EN when defined.
module tb_fib_seq;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  n = '0;
    logic        busy, done, overflow;
    logic [31:0] result, alu_src0, alu_src1, alu_result;
    logic [1:0]  alu_aluop;
    logic        alu_zero;
`ifdef FIB_SEQ_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    fib_seq #(.N_WIDTH(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .alu_src0   (alu_src0),
        .alu_src1   (alu_src1),
        .alu_aluop  (alu_aluop),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
`ifdef FIB_SEQ_CYCLE_CNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    always_comb begin
        case (alu_aluop)
            2'b00:   alu_result = alu_src0 + alu_src1;
            2'b01:   alu_result = alu_src0 - alu_src1;
            2'b10:   alu_result = {31'd0, $signed(alu_src0) < $signed(alu_src1)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          edge_n;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    exp_t e;
    bit   chk_idle = 1'b0;
    always @(negedge clk) begin
        if (chk_idle) begin
            chk("busy_after_done", {31'd0, busy}, 32'd0);
            chk_idle = 1'b0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("done_edge", cyc, e.edge_n);
`ifdef FIB_SEQ_CYCLE_CNT_EN
                chk("cycles", {16'd0, cycles}, {16'd0, e.cnt});
`endif
                chk_idle = 1'b1;
            end
        end
    end

    task automatic push_exp(input int nn, input logic [31:0] res, input logic ovf, input logic [15:0] cnt);
        exp_t x;
        x.res    = res;
        x.ovf    = ovf;
        x.edge_n = cyc + 2 + 3 * nn;
        x.cnt    = cnt;
        sb.push_back(x);
    endtask

    task automatic issue(input int nn, input logic [31:0] res, input logic ovf, input logic [15:0] cnt);
        push_exp(nn, res, ovf, cnt);
        n     = 6'(nn);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cmp_src0", alu_src0, 32'd0);
        chk("cmp_src1", alu_src1, 32'(nn));
        chk("cmp_op", {30'd0, alu_aluop}, 32'd2);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 400 cycles");
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic run(input int nn, input logic [31:0] res, input logic ovf, input logic [15:0] cnt);
        issue(nn, res, ovf, cnt);
        wait_idle();
    endtask

    typedef struct {
        int          nn;
        logic [31:0] res;
        logic        ovf;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[5] = '{
        '{0,  32'h0000_0000, 1'b0, 16'd1},
        '{1,  32'h0000_0001, 1'b0, 16'd4},
        '{10, 32'h0000_0037, 1'b0, 16'd31},
        '{47, 32'hB119_24E1, 1'b0, 16'd142},
        '{48, 32'h1E8D_0A40, 1'b1, 16'd145}
    };

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_alu", alu_src0 | alu_src1 | {30'd0, alu_aluop}, 32'd0);
`ifdef FIB_SEQ_CYCLE_CNT_EN
        chk("rst_cycles", {16'd0, cycles}, 32'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[j]) run(vecs[j].nn, vecs[j].res, vecs[j].ovf, vecs[j].cnt);

        repeat (3) @(negedge clk);
        chk("result_held", result, 32'h1E8D_0A40);
        chk("overflow_held", {31'd0, overflow}, 32'd1);
`ifdef FIB_SEQ_CYCLE_CNT_EN
        chk("cycles_held", {16'd0, cycles}, 32'd145);
`endif

        // start held high and n changed mid-run must not disturb the n=5 run
        push_exp(5, 32'h0000_0005, 1'b0, 16'd16);
        n     = 6'd5;
        start = 1'b1;
        @(negedge clk);
        n = 6'd20;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 expected done within 100 cycles");
        end
        wait_idle();
        run(20, 32'h0000_1A6D, 1'b0, 16'd61);

        // Asynchronous reset while the n=30 run sits in INC
        n     = 6'd30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("inc_src1", alu_src1, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        run(3, 32'h0000_0002, 1'b0, 16'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
